// File: rtl/dut_vector_sequencer.sv
// Command-driven sequencer for the double-buffered DUT register bank.
// Optional ABORT input enabled by defining DUT_SEQ_ABORT_EN.
`timescale 1ns/1ps

module dut_vector_sequencer #(
    parameter int CYC_W = 8,
    parameter int BUS_W = 126
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_TYPE,
    input  logic [BUS_W-1:0] CMD_DATA,
    input  logic [CYC_W-1:0] RUN_LENGTH,
    output logic [BUS_W-1:0] BUS126,
    output logic             SIG_LOAD,
    output logic             FF_LOAD_FF,
    output logic             TEMPLATE_LOAD,
    output logic             CYCLE_LOAD,
    output logic             SIG_TRANSFER,
    output logic             FF_TRANSFER_FF,
    output logic             TEMPLATE_TRANSFER,
    output logic             CYCLE_TRANSFER,
    output logic             FF_LOAD_SIG,
    output logic             FF_TRANSFER_SIG,
    output logic             PERFORM_TEST,
    output logic             BUSY,
    output logic             VECTOR_DONE
`ifdef DUT_SEQ_ABORT_EN
    ,
    input  logic             ABORT
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XFER1 = 3'd1,
        S_XFER2 = 3'd2,
        S_XFER3 = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] CMD_COMMIT = 3'd4;

    state_t             r_state;
    state_t             w_next;

    // Dirty bits indexed by load type: [0] sig, [1] ff, [2] template, [3] cycle
    logic [3:0]         r_dirty;
    logic [3:0]         w_dirty_nxt;
    logic [CYC_W-1:0]   r_cnt;

    logic               r_rdy_load;
    logic               r_rdy_commit;
    logic [BUS_W-1:0]   r_bus;
    logic [3:0]         r_load;
    logic [3:0]         r_xfer;
    logic               r_ff_load_sig;
    logic               r_ff_xfer_sig;
    logic               r_perform;
    logic               r_busy;
    logic               r_done;

    logic               w_abort;
    logic               w_accept;
    logic               w_is_commit;
    logic               w_is_load;
    logic               w_commit_acc;
    logic               w_load_acc;

    logic               w_rdy_load;
    logic               w_rdy_commit;
    logic [3:0]         w_load;
    logic [3:0]         w_xfer;
    logic               w_ff_load_sig;
    logic               w_ff_xfer_sig;
    logic               w_perform;
    logic               w_busy;
    logic               w_done;

`ifdef DUT_SEQ_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    // Ready is held in registers per command class; the type only selects which one applies.
    assign CMD_READY    = w_is_commit ? r_rdy_commit : r_rdy_load;
    assign w_is_commit  = (CMD_TYPE == CMD_COMMIT);
    assign w_is_load    = (CMD_TYPE[2] == 1'b0);
    assign w_accept     = CMD_VALID & CMD_READY;
    assign w_commit_acc = w_accept & w_is_commit;
    assign w_load_acc   = w_accept & w_is_load;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_commit_acc) w_next = S_XFER1;
            S_XFER1: w_next = r_dirty[0] ? S_XFER2 : S_RUN;
            S_XFER2: w_next = S_XFER3;
            S_XFER3: w_next = S_RUN;
            S_RUN:   if (r_cnt <= CYC_W'(1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        w_load = '0;
        if (w_load_acc) begin
            w_load[CMD_TYPE[1:0]] = 1'b1;
        end
        w_xfer        = (w_next == S_XFER1) ? (r_dirty & ~{4{w_abort}}) : '0;
        w_ff_load_sig = (w_next == S_XFER2);
        w_ff_xfer_sig = (w_next == S_XFER3);
        w_perform     = (w_next == S_RUN);
        w_done        = (w_next == S_DONE);
        w_busy        = (w_next != S_IDLE);
        w_rdy_commit  = (w_next == S_IDLE);
        w_rdy_load    = !((w_next == S_XFER1) || (w_next == S_XFER2) || (w_next == S_XFER3));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rdy_load    <= 1'b0;
            r_rdy_commit  <= 1'b0;
            r_load        <= '0;
            r_xfer        <= '0;
            r_ff_load_sig <= 1'b0;
            r_ff_xfer_sig <= 1'b0;
            r_perform     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_rdy_load    <= w_rdy_load;
            r_rdy_commit  <= w_rdy_commit;
            r_load        <= w_load;
            r_xfer        <= w_xfer;
            r_ff_load_sig <= w_ff_load_sig;
            r_ff_xfer_sig <= w_ff_xfer_sig;
            r_perform     <= w_perform;
            r_busy        <= w_busy;
            r_done        <= w_done;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bus <= '0;
        end else if (w_load_acc) begin
            r_bus <= CMD_DATA;
        end
    end

    always_comb begin
        w_dirty_nxt = r_dirty;
        if (r_state == S_XFER1) begin
            w_dirty_nxt[3:1] = '0;
        end
        if (r_state == S_XFER3) begin
            w_dirty_nxt[0] = 1'b0;
        end
        if (w_load_acc) begin
            w_dirty_nxt[CMD_TYPE[1:0]] = 1'b1;
        end
        if (w_abort) begin
            w_dirty_nxt = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= w_dirty_nxt;
        end
    end

    // Remaining RUN cycles; a zero length is promoted to one at COMMIT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (w_commit_acc) begin
            r_cnt <= (RUN_LENGTH == '0) ? CYC_W'(1) : RUN_LENGTH;
        end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CYC_W'(1);
        end
    end

    assign BUS126            = r_bus;
    assign SIG_LOAD          = r_load[0];
    assign FF_LOAD_FF        = r_load[1];
    assign TEMPLATE_LOAD     = r_load[2];
    assign CYCLE_LOAD        = r_load[3];
    assign SIG_TRANSFER      = r_xfer[0];
    assign FF_TRANSFER_FF    = r_xfer[1];
    assign TEMPLATE_TRANSFER = r_xfer[2];
    assign CYCLE_TRANSFER    = r_xfer[3];
    assign FF_LOAD_SIG       = r_ff_load_sig;
    assign FF_TRANSFER_SIG   = r_ff_xfer_sig;
    assign PERFORM_TEST      = r_perform;
    assign BUSY              = r_busy;
    assign VECTOR_DONE       = r_done;

endmodule
